// File: rtl/step_pulse_gen_pkg.sv
// Shared board constants and types for the step/direction input stage.
// Other labs import this so debounce and tick timing stay consistent.
package step_pulse_gen_pkg;

  localparam int unsigned ClockFreqHz     = 100_000_000;
  localparam int unsigned DbCountDefault  = ClockFreqHz / 100;  // 10 ms
  localparam int unsigned DivCountDefault = ClockFreqHz;        // 1 Hz

  typedef enum logic {
    ModeManual = 1'b0,
    ModeAuto   = 1'b1
  } mode_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_pulse_gen_debouncer.sv
// 2-FF synchronizer followed by a consecutive-sample debounce filter.
// The stable state flips only after DB_COUNT mismatching samples in a row.
module debouncer
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned DB_COUNT = DbCountDefault
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int unsigned     CntW    = cnt_width(DB_COUNT);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_COUNT - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Turns raw button/switch inputs into a one-cycle step pulse and a
// direction level that never moves next to a step.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned DB_COUNT  = DbCountDefault,
  parameter int unsigned DIV_COUNT = DivCountDefault
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_step,
  input  logic sw_dir,
  input  logic sw_auto,
  output logic step,
  output logic dir,
  output logic auto_led
);

  localparam int unsigned     DivW    = cnt_width(DIV_COUNT);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV_COUNT - 1);

  logic            btn_db, dir_db, auto_db;
  mode_e           mode, mode_prev_q;
  logic            btn_prev_q;
  logic [DivW-1:0] div_q, div_d;
  logic            req;
  logic            step_q;
  logic            dir_q, dir_d;

  debouncer #(.DB_COUNT(DB_COUNT)) u_db_btn (
    .clock    (clock),
    .reset    (reset),
    .raw_i    (btn_step),
    .stable_o (btn_db)
  );

  debouncer #(.DB_COUNT(DB_COUNT)) u_db_dir (
    .clock    (clock),
    .reset    (reset),
    .raw_i    (sw_dir),
    .stable_o (dir_db)
  );

  debouncer #(.DB_COUNT(DB_COUNT)) u_db_auto (
    .clock    (clock),
    .reset    (reset),
    .raw_i    (sw_auto),
    .stable_o (auto_db)
  );

  assign mode = mode_e'(auto_db);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_prev_q  <= 1'b0;
      mode_prev_q <= ModeManual;
      div_q       <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      btn_prev_q  <= btn_db;
      mode_prev_q <= mode;
      div_q       <= div_d;
      step_q      <= req;
      dir_q       <= dir_d;
    end
  end

  // The divider idles at 0 on the entry cycle so the first tick lands
  // DIV_COUNT+1 edges after the mode qualifies; leaving auto clears it at once.
  always_comb begin
    div_d = '0;
    if (mode == ModeAuto && mode_prev_q == ModeAuto) begin
      div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
    end
  end

  always_comb begin
    req = 1'b0;
    case (mode)
      ModeManual: req = btn_db & ~btn_prev_q;
      ModeAuto:   req = (mode_prev_q == ModeAuto) && (div_q == DivLast);
      default:    req = 1'b0;
    endcase
  end

  // Hold direction while a step is pending or in flight.
  assign dir_d = (!step_q && !req) ? dir_db : dir_q;

  assign step     = step_q;
  assign dir      = dir_q;
  assign auto_led = auto_db;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Randomized and directed checks of step_pulse_gen against a behavioural
// model built from window-based debouncing and arithmetic tick timing.
module tb_step_pulse_gen;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 10;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic btn_step = 1'b0;
  logic sw_dir   = 1'b0;
  logic sw_auto  = 1'b0;
  logic step, dir, auto_led;

  step_pulse_gen #(.DB_COUNT(DB), .DIV_COUNT(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_step (btn_step),
    .sw_dir   (sw_dir),
    .sw_auto  (sw_auto),
    .step     (step),
    .dir      (dir),
    .auto_led (auto_led)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Model state: index 0 = button, 1 = direction, 2 = mode.
  logic [2:0]    s1, s2, stab;
  logic [DB-1:0] win [3];
  logic          m_step, m_dir, m_req;
  int            r_edge;

  task automatic check(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    s1 = '0; s2 = '0; stab = '0;
    for (int i = 0; i < 3; i++) win[i] = '0;
    m_step = 1'b0; m_dir = 1'b0; m_req = 1'b0; r_edge = 0;
  endtask

  // Advance the model across one clock edge (edge number cyc).
  task automatic model_edge();
    logic [2:0] raw;
    logic       samp, new_step, b_prev, a_prev;
    raw      = {sw_auto, sw_dir, btn_step};
    new_step = m_req;
    if (!m_step && !m_req) m_dir = stab[1];
    m_step = new_step;
    b_prev = stab[0];
    a_prev = stab[2];
    for (int i = 0; i < 3; i++) begin
      samp  = s2[i];
      s2[i] = s1[i];
      s1[i] = raw[i];
      win[i] = {win[i][DB-2:0], samp};
      if (win[i] == {DB{~stab[i]}}) stab[i] = ~stab[i];
    end
    if (stab[2] && !a_prev) r_edge = cyc;
    if (stab[2]) m_req = ((cyc - r_edge) >= int'(DIV)) && (((cyc - r_edge) % DIV) == 0);
    else         m_req = stab[0] && !b_prev;
  endtask

  task automatic compare_all();
    check("step", step, m_step);
    check("dir", dir, m_dir);
    check("auto_led", auto_led, stab[2]);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (!reset) model_edge();
    compare_all();
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_now_step", step, 1'b0);
    check("rst_now_dir", dir, 1'b0);
    check("rst_now_auto", auto_led, 1'b0);
  endtask

  task automatic wait_step(output int s);
    s = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (step === 1'b1) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) check_int("wait_step_timeout", 0, 1);
  endtask

  initial begin
    int s, t, cnt, first, prev;
    model_reset();

    // Reset held with inputs toggling.
    for (int i = 0; i < 6; i++) begin
      btn_step = 1'($urandom_range(0, 1));
      sw_dir   = 1'($urandom_range(0, 1));
      sw_auto  = 1'($urandom_range(0, 1));
      tick();
      check("rst_hold_step", step, 1'b0);
    end
    btn_step = 1'b0; sw_dir = 1'b1; sw_auto = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) check("dir_pre_release", dir, 1'b0);
      if (k == 7) check("dir_after_7", dir, 1'b1);
    end

    // Bounce, then hold high, then release.
    for (int i = 0; i < 12; i++) begin
      btn_step = ((i / 2) % 2) == 0;
      tick();
    end
    btn_step = 1'b1;
    t = cyc; cnt = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step) begin cnt++; if (first < 0) first = cyc; end
    end
    check_int("bounce_pulses", cnt, 1);
    check_int("bounce_latency", first - t, 7);
    btn_step = 1'b0; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step) cnt++;
    end
    check_int("release_pulses", cnt, 0);

    // Auto mode with button activity that must be ignored.
    sw_auto = 1'b1; t = cyc; first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      tick();
      if (auto_led) first = cyc;
    end
    check_int("auto_led_latency", first - t, 6);
    t = first;
    wait_step(s);
    check_int("auto_first_step", s - t, 11);
    prev = s; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) btn_step = ~btn_step;
      if (i >= 30) btn_step = 1'b0;
      tick();
      if (step) begin
        cnt++;
        check_int("auto_period", cyc - prev, 10);
        prev = cyc;
      end
    end
    check_int("auto_pulses", cnt, 4);

    // Direction change landing on the request cycle is held off.
    wait_step(s);
    while (cyc < s + 3) tick();
    sw_dir = 1'b0;
    first = -1;
    for (int i = 0; i < 30 && first < 0; i++) begin
      tick();
      if (cyc == s + 10) begin
        check("blk_step", step, 1'b1);
        check("blk_old_dir", dir, 1'b1);
      end
      if (dir == 1'b0) first = cyc;
    end
    check_int("blk_dir_change", first - s, 12);

    // Reset with the divider at 7.
    wait_step(s);
    while (cyc < s + 7) tick();
    assert_reset();
    tick();
    reset = 1'b0;
    t = cyc; first = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (auto_led && first < 0) first = cyc;
      if (step) break;
    end
    check_int("rst_redebounce", first - t, 6);
    check_int("rst_first_step", cyc - t, 17);

    // Leave auto mode with the divider at 9.
    wait_step(s);
    while (cyc < s + 3) tick();
    sw_auto = 1'b0;
    while (cyc < s + 9) tick();
    check("mode_auto_off", auto_led, 1'b0);
    tick();
    check("mode_no_step", step, 1'b0);
    btn_step = 1'b1; cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) btn_step = 1'b0;
      tick();
      if (step) cnt++;
    end
    check_int("manual_press", cnt, 1);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)  btn_step = ~btn_step;
      if ($urandom_range(0, 14) == 0) sw_dir   = ~sw_dir;
      if ($urandom_range(0, 59) == 0) sw_auto  = ~sw_auto;
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
